// File: rtl/clock_rtc.sv
// Real-time clock: prescaler-divided one-second ticks driving a sec/min/hour counter.
// Supports range-checked time loads and a single alarm compare on each advance.
module clock_rtc #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26,
    parameter int HOURS    = 24
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       run,
    input  logic       set_valid,
    input  logic [5:0] set_sec,
    input  logic [5:0] set_min,
    input  logic [5:0] set_hour,
    input  logic       alarm_we,
    input  logic [5:0] alarm_sec,
    input  logic [5:0] alarm_min,
    input  logic [5:0] alarm_hour,
    input  logic       alarm_en,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hour,
    output logic       tick,
    output logic       day_wrap,
    output logic       alarm,
    output logic       set_err
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [5:0]       HOUR_LAST  = 6'(HOURS - 1);
    localparam logic [6:0]       HOUR_LIM   = 7'(HOURS);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [5:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [5:0]       alarm_sec_q, alarm_sec_d, alarm_min_q, alarm_min_d;
    logic [5:0]       alarm_hour_q, alarm_hour_d;
    logic             tick_q, tick_d, day_wrap_q, day_wrap_d;
    logic             alarm_q, alarm_d, set_err_q, set_err_d;
    logic             advance_s, set_ok_s;

    // Next-state: set beats advance; advance beats plain prescaler counting.
    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        tick_d     = 1'b0;
        day_wrap_d = 1'b0;
        alarm_d    = 1'b0;
        advance_s  = run && (presc_q >= PRESC_LAST);
        set_ok_s   = set_valid && (set_sec < 6'd60) && (set_min < 6'd60)
                     && ({1'b0, set_hour} < HOUR_LIM);
        set_err_d  = set_valid && !set_ok_s;

        if (set_ok_s) begin
            presc_d = '0;
            sec_d   = set_sec;
            min_d   = set_min;
            hour_d  = set_hour;
        end else if (advance_s) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q >= 6'd59) begin
                sec_d = 6'd0;
                if (min_q >= 6'd59) begin
                    min_d = 6'd0;
                    if (hour_q >= HOUR_LAST) begin
                        hour_d     = 6'd0;
                        day_wrap_d = 1'b1;
                    end else begin
                        hour_d = hour_q + 6'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
            // Compare against the alarm registers as they stood before this edge.
            alarm_d = alarm_en && (sec_d == alarm_sec_q) && (min_d == alarm_min_q)
                      && (hour_d == alarm_hour_q);
        end else if (run) begin
            presc_d = presc_q + DIV_W'(1);
        end else begin
            presc_d = presc_q;
        end

        if (alarm_we) begin
            alarm_sec_d  = alarm_sec;
            alarm_min_d  = alarm_min;
            alarm_hour_d = alarm_hour;
        end else begin
            alarm_sec_d  = alarm_sec_q;
            alarm_min_d  = alarm_min_q;
            alarm_hour_d = alarm_hour_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            presc_q      <= '0;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            hour_q       <= 6'd0;
            alarm_sec_q  <= 6'd0;
            alarm_min_q  <= 6'd0;
            alarm_hour_q <= 6'd0;
            tick_q       <= 1'b0;
            day_wrap_q   <= 1'b0;
            alarm_q      <= 1'b0;
            set_err_q    <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            alarm_sec_q  <= alarm_sec_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            tick_q       <= tick_d;
            day_wrap_q   <= day_wrap_d;
            alarm_q      <= alarm_d;
            set_err_q    <= set_err_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign tick     = tick_q;
    assign day_wrap = day_wrap_q;
    assign alarm    = alarm_q;
    assign set_err  = set_err_q;

endmodule

// File: tb/tb_clock_rtc.sv
// Directed self-checking bench for clock_rtc with TICK_DIV=4, HOURS=24.
module tb_clock_rtc;

    logic       clock = 1'b0;
    logic       resetn, run, set_valid, alarm_we, alarm_en;
    logic [5:0] set_sec, set_min, set_hour, alarm_sec, alarm_min, alarm_hour;
    logic [5:0] sec, min, hour;
    logic       tick, day_wrap, alarm, set_err;
    int         n_tests = 0;
    int         n_fail  = 0;

    clock_rtc #(.TICK_DIV(4), .DIV_W(4), .HOURS(24)) dut (
        .clock(clock), .resetn(resetn), .run(run), .set_valid(set_valid),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
        .alarm_we(alarm_we), .alarm_sec(alarm_sec), .alarm_min(alarm_min),
        .alarm_hour(alarm_hour), .alarm_en(alarm_en),
        .sec(sec), .min(min), .hour(hour), .tick(tick), .day_wrap(day_wrap),
        .alarm(alarm), .set_err(set_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check_eq({tag, "_hour"}, 32'(hour), 32'(h));
        check_eq({tag, "_min"}, 32'(min), 32'(m));
        check_eq({tag, "_sec"}, 32'(sec), 32'(s));
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 6'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        step();
        set_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; run = 1'b1; set_valid = 1'b1; alarm_we = 1'b1; alarm_en = 1'b1;
        set_sec = 6'd7; set_min = 6'd7; set_hour = 6'd7;
        alarm_sec = 6'd1; alarm_min = 6'd0; alarm_hour = 6'd0;
        #2;
        step();
        check_time("reset", 0, 0, 0);
        check_eq("reset_tick", 32'(tick), 32'd0);
        check_eq("reset_flags", 32'({day_wrap, alarm, set_err}), 32'd0);

        // Basic counting from reset: tick every 4th edge.
        resetn = 1'b1; set_valid = 1'b0; alarm_we = 1'b0; alarm_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_eq($sformatf("cnt_tick%0d", k), 32'(tick), 32'((k % 4) == 0));
            check_eq($sformatf("cnt_sec%0d", k), 32'(sec), 32'(k / 4));
        end

        // Reset mid-count discards the partial prescaler value.
        step(); step();
        resetn = 1'b0;
        step();
        check_time("midrst", 0, 0, 0);
        resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq($sformatf("midrst_tick%0d", k), 32'(tick), 32'(k == 4));
        end
        check_eq("midrst_sec", 32'(sec), 32'd1);

        // Pause holds everything; resume keeps the remaining count.
        step(); step();
        run = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_eq($sformatf("hold_tick%0d", k), 32'(tick), 32'd0);
            check_eq($sformatf("hold_sec%0d", k), 32'(sec), 32'd1);
        end
        run = 1'b1;
        step();
        check_eq("resume_tick1", 32'(tick), 32'd0);
        step();
        check_eq("resume_tick2", 32'(tick), 32'd1);
        check_eq("resume_sec", 32'(sec), 32'd2);

        // Day wrap from 23:59:58.
        do_set(23, 59, 58);
        check_time("set2359", 23, 59, 58);
        check_eq("set2359_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq($sformatf("wrap_tick%0d", k), 32'(tick), 32'((k % 4) == 0));
            check_eq($sformatf("wrap_dw%0d", k), 32'(day_wrap), 32'(k == 8));
            if (k == 4) check_time("wrap_59", 23, 59, 59);
        end
        check_time("wrap_0", 0, 0, 0);

        // Out-of-range set: error pulse, time and prescaler untouched.
        step(); step();
        do_set(24, 0, 0);
        check_eq("bad_err", 32'(set_err), 32'd1);
        check_eq("bad_tick", 32'(tick), 32'd0);
        check_time("bad_time", 0, 0, 0);
        step();
        check_eq("bad_err_clr", 32'(set_err), 32'd0);
        check_eq("bad_adv_tick", 32'(tick), 32'd1);
        check_eq("bad_adv_sec", 32'(sec), 32'd1);
        step(); step(); step();
        do_set(0, 60, 0);
        check_eq("bad2_err", 32'(set_err), 32'd1);
        check_eq("bad2_tick", 32'(tick), 32'd1);
        check_eq("bad2_sec", 32'(sec), 32'd2);

        // Valid set on an advance edge wins; next tick 4 edges later.
        step(); step(); step();
        do_set(10, 20, 30);
        check_eq("setadv_tick", 32'(tick), 32'd0);
        check_time("setadv", 10, 20, 30);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq($sformatf("setadv_tick%0d", k), 32'(tick), 32'(k == 4));
        end
        check_eq("setadv_sec", 32'(sec), 32'd31);

        // Alarm at 0:00:05 from reset.
        resetn = 1'b0;
        step();
        resetn = 1'b1; run = 1'b0; alarm_we = 1'b1; alarm_en = 1'b1;
        alarm_sec = 6'd5; alarm_min = 6'd0; alarm_hour = 6'd0;
        step();
        alarm_we = 1'b0; run = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check_eq($sformatf("alm_%0d", k), 32'(alarm), 32'(k == 20));
        end
        check_eq("alm_sec", 32'(sec), 32'd6);
        do_set(0, 0, 5);
        check_eq("alm_set", 32'(alarm), 32'd0);

        // Alarm write coincident with an advance compares old registers.
        step(); step(); step();
        alarm_we = 1'b1; alarm_sec = 6'd6;
        step();
        alarm_we = 1'b0;
        check_eq("almwe_sec", 32'(sec), 32'd6);
        check_eq("almwe_old", 32'(alarm), 32'd0);
        do_set(0, 0, 5);
        step(); step(); step(); step();
        check_eq("almwe_new", 32'(alarm), 32'd1);

        // alarm_en low suppresses a match.
        do_set(0, 0, 5);
        alarm_en = 1'b0;
        step(); step(); step(); step();
        check_eq("almdis_tick", 32'(tick), 32'd1);
        check_eq("almdis", 32'(alarm), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
